// File: rtl/ioctl_loader.sv
// Host download loader: buffers ioctl byte writes through a 2-entry FIFO into slot-based memory.
// Optional LOADER_CHECKSUM_EN adds a running mod-256 checksum of accepted bytes.
module ioctl_loader #(
    parameter int ADDR_W     = 14,
    parameter int MEM_AW     = 25,
    parameter int NSLOTS     = 2,
    parameter int SLOT_SHIFT = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              dn_go,
    input  logic              dn_wr,
    input  logic [ADDR_W-1:0] dn_addr,
    input  logic [7:0]        dn_data,
    input  logic [7:0]        dn_idx,
    output logic              dn_wait,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wr,
    input  logic              mem_ack,
    output logic              rom_reset,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   byte_count,
    output logic [7:0]        checksum
);

    localparam longint unsigned SlotSpan = longint'(NSLOTS) << SLOT_SHIFT;
    localparam longint unsigned MemSpan  = 64'd1 << MEM_AW;

    if (SLOT_SHIFT < ADDR_W || SlotSpan > MemSpan) begin : g_bad_cfg
        $error("ioctl_loader: slot layout does not fit ADDR_W/MEM_AW");
    end

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [7:0]        idx_q;
    logic [ADDR_W:0]   byte_count_q;
    logic              err_q;
    logic [MEM_AW-1:0] fifo_addr_q [2];
    logic [7:0]        fifo_data_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;

    logic start, full, empty, slot_ok, push, pop, drop;

    assign start   = (state_q == StIdle) && dn_go;
    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign slot_ok = int'(idx_q) < NSLOTS;
    assign dn_wait = full || (state_q == StDrain) || (state_q == StDone);
    assign push    = dn_wr && (state_q == StLoad) && !full && slot_ok;
    assign drop    = dn_wr && !push;
    assign mem_wr  = !empty;
    assign pop     = mem_wr && mem_ack;

    // Outputs read zero while idle so reset and drained states look identical.
    assign mem_addr   = mem_wr ? fifo_addr_q[rd_ptr_q] : '0;
    assign mem_data   = mem_wr ? fifo_data_q[rd_ptr_q] : '0;
    assign rom_reset  = (state_q != StIdle) && (idx_q == 8'd0);
    assign done       = (state_q == StDone);
    assign err        = err_q;
    assign byte_count = byte_count_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (dn_go) state_d = StLoad;
            StLoad:  if (!dn_go) state_d = StDrain;
            StDrain: if (empty) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            byte_count_q <= '0;
            err_q        <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (start) begin
                idx_q        <= dn_idx;
                byte_count_q <= '0;
                err_q        <= 1'b0;
            end else begin
                if (push && byte_count_q != '1) begin
                    byte_count_q <= byte_count_q + (ADDR_W+1)'(1);
                end
                if (drop) begin
                    err_q <= 1'b1;
                end
            end
            if (push) begin
                fifo_addr_q[wr_ptr_q] <= (MEM_AW'(idx_q) << SLOT_SHIFT) | MEM_AW'(dn_addr);
                fifo_data_q[wr_ptr_q] <= dn_data;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            checksum_q <= 8'd0;
        end else if (start) begin
            checksum_q <= 8'd0;
        end else if (push) begin
            checksum_q <= checksum_q + dn_data;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 8'd0;
`endif

endmodule

// File: tb/tb_ioctl_loader.sv
// Directed bench for ioctl_loader: outputs sampled on the falling edge, inputs driven just after it.
module tb_ioctl_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        dn_go, dn_wr, mem_ack;
    logic [13:0] dn_addr;
    logic [7:0]  dn_data, dn_idx;
    logic        dn_wait, mem_wr, rom_reset, done, err;
    logic [24:0] mem_addr;
    logic [7:0]  mem_data, checksum;
    logic [14:0] byte_count;

    int tests = 0;
    int fails = 0;

`ifdef LOADER_CHECKSUM_EN
    localparam logic [7:0] CsA = 8'h33;
    localparam logic [7:0] CsE = 8'h10;
`else
    localparam logic [7:0] CsA = 8'h00;
    localparam logic [7:0] CsE = 8'h00;
`endif

    always #5 clk_sys = ~clk_sys;

    ioctl_loader #(
        .ADDR_W    (14),
        .MEM_AW    (25),
        .NSLOTS    (2),
        .SLOT_SHIFT(16)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .dn_go     (dn_go),
        .dn_wr     (dn_wr),
        .dn_addr   (dn_addr),
        .dn_data   (dn_data),
        .dn_idx    (dn_idx),
        .dn_wait   (dn_wait),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wr    (mem_wr),
        .mem_ack   (mem_ack),
        .rom_reset (rom_reset),
        .done      (done),
        .err       (err),
        .byte_count(byte_count),
        .checksum  (checksum)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic wr(input logic [13:0] a, input logic [7:0] d);
        dn_wr   = 1'b1;
        dn_addr = a;
        dn_data = d;
    endtask

    initial begin
        reset_n = 1'b0;
        dn_go   = 1'b0;
        dn_wr   = 1'b0;
        dn_addr = '0;
        dn_data = '0;
        dn_idx  = '0;
        mem_ack = 1'b1;
        tick();
        tick();
        check("rst_mem_wr", 32'(mem_wr), 0);
        check("rst_dn_wait", 32'(dn_wait), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_rom_reset", 32'(rom_reset), 0);
        check("rst_byte_count", 32'(byte_count), 0);
        check("rst_checksum", 32'(checksum), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_data", 32'(mem_data), 0);
        reset_n = 1'b1;
        tick();

        // Slot 0 download of two bytes, ack tied high
        dn_idx = 8'd0;
        dn_go  = 1'b1;
        tick();
        check("a_rom_reset_load", 32'(rom_reset), 1);
        check("a_mem_wr_idle", 32'(mem_wr), 0);
        wr(14'd0, 8'h11);
        tick();
        check("a_mem_wr0", 32'(mem_wr), 1);
        check("a_mem_addr0", 32'(mem_addr), 32'h0000000);
        check("a_mem_data0", 32'(mem_data), 32'h11);
        check("a_count1", 32'(byte_count), 1);
        wr(14'd1, 8'h22);
        tick();
        check("a_mem_wr1", 32'(mem_wr), 1);
        check("a_mem_addr1", 32'(mem_addr), 32'h0000001);
        check("a_mem_data1", 32'(mem_data), 32'h22);
        check("a_count2", 32'(byte_count), 2);
        dn_wr = 1'b0;
        dn_go = 1'b0;
        tick();
        check("a_drain_mem_wr", 32'(mem_wr), 0);
        check("a_drain_wait", 32'(dn_wait), 1);
        check("a_drain_rom_reset", 32'(rom_reset), 1);
        check("a_drain_done", 32'(done), 0);
        tick();
        check("a_done", 32'(done), 1);
        check("a_done_rom_reset", 32'(rom_reset), 1);
        tick();
        check("a_done_cleared", 32'(done), 0);
        check("a_idle_rom_reset", 32'(rom_reset), 0);
        check("a_final_count", 32'(byte_count), 2);
        check("a_final_err", 32'(err), 0);
        check("a_checksum", 32'(checksum), 32'(CsA));

        // Slot 1 at top of window
        dn_idx = 8'd1;
        dn_go  = 1'b1;
        tick();
        check("b_rom_reset_load", 32'(rom_reset), 0);
        wr(14'h3FFF, 8'hA5);
        tick();
        check("b_mem_wr", 32'(mem_wr), 1);
        check("b_mem_addr", 32'(mem_addr), 32'h0013FFF);
        check("b_mem_data", 32'(mem_data), 32'hA5);
        dn_wr = 1'b0;
        dn_go = 1'b0;
        tick();
        tick();
        check("b_done", 32'(done), 1);
        check("b_done_rom_reset", 32'(rom_reset), 0);
        tick();

        // Back-pressure with ack held low, then reset with two entries queued
        mem_ack = 1'b0;
        dn_idx  = 8'd0;
        dn_go   = 1'b1;
        tick();
        wr(14'd0, 8'h01);
        tick();
        check("c_wait_after1", 32'(dn_wait), 0);
        check("c_mem_wr", 32'(mem_wr), 1);
        check("c_head_data1", 32'(mem_data), 32'h01);
        wr(14'd1, 8'h02);
        tick();
        check("c_wait_after2", 32'(dn_wait), 1);
        check("c_err_before_drop", 32'(err), 0);
        check("c_head_stable", 32'(mem_data), 32'h01);
        wr(14'd2, 8'h03);
        tick();
        check("c_err_drop", 32'(err), 1);
        check("c_count_sat_fifo", 32'(byte_count), 2);
        check("c_still_wait", 32'(dn_wait), 1);
        dn_wr   = 1'b0;
        reset_n = 1'b0;
        tick();
        check("r_mem_wr", 32'(mem_wr), 0);
        check("r_dn_wait", 32'(dn_wait), 0);
        check("r_rom_reset", 32'(rom_reset), 0);
        check("r_err", 32'(err), 0);
        check("r_count", 32'(byte_count), 0);
        mem_ack = 1'b1;
        reset_n = 1'b1;
        tick();
        check("r_restart_load", 32'(rom_reset), 1);
        check("r_no_stale_wr", 32'(mem_wr), 0);
        dn_go = 1'b0;
        tick();
        check("r_drain_no_wr", 32'(mem_wr), 0);
        tick();
        check("r_done", 32'(done), 1);
        tick();

        // Out-of-range slot index
        dn_idx = 8'd5;
        dn_go  = 1'b1;
        tick();
        wr(14'd0, 8'h77);
        tick();
        check("d_no_mem_wr", 32'(mem_wr), 0);
        check("d_err", 32'(err), 1);
        check("d_count", 32'(byte_count), 0);
        dn_wr = 1'b0;
        dn_go = 1'b0;
        tick();
        tick();
        check("d_done", 32'(done), 1);
        tick();
        check("d_done_once", 32'(done), 0);

        // Checksum wrap over two bytes
        dn_idx = 8'd1;
        dn_go  = 1'b1;
        tick();
        check("e_err_cleared", 32'(err), 0);
        wr(14'd0, 8'hF0);
        tick();
        wr(14'd1, 8'h20);
        tick();
        dn_wr = 1'b0;
        dn_go = 1'b0;
        tick();
        tick();
        check("e_done", 32'(done), 1);
        tick();
        check("e_checksum", 32'(checksum), 32'(CsE));
        check("e_count", 32'(byte_count), 2);
        tick();
        check("e_checksum_hold", 32'(checksum), 32'(CsE));

        // dn_go reasserted during DRAIN/DONE is ignored until IDLE
        dn_idx = 8'd0;
        dn_go  = 1'b1;
        tick();
        dn_go = 1'b0;
        tick();
        check("f_drain_wait", 32'(dn_wait), 1);
        dn_go = 1'b1;
        tick();
        check("f_done", 32'(done), 1);
        tick();
        check("f_idle_done", 32'(done), 0);
        check("f_idle_rom_reset", 32'(rom_reset), 0);
        check("f_idle_wait", 32'(dn_wait), 0);
        tick();
        check("f_reload", 32'(rom_reset), 1);
        dn_go = 1'b0;
        tick();
        tick();
        tick();

        // Strobe outside LOAD flags an error
        check("g_err_clear", 32'(err), 0);
        wr(14'd4, 8'h55);
        tick();
        dn_wr = 1'b0;
        check("g_err_idle_wr", 32'(err), 1);
        check("g_idle_no_wr", 32'(mem_wr), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ioctl_loader.md
IOCTL_LOADER -- requirements
Module: ioctl_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, width of host download byte address.
REQ-002 SHALL have parameter MEM_AW, default 25, width of memory-side byte address.
REQ-003 SHALL have parameter NSLOTS, default 2, number of valid download indices (0..NSLOTS-1).
REQ-004 SHALL have parameter SLOT_SHIFT, default 16, slot base = index << SLOT_SHIFT; elaboration SHALL fail if SLOT_SHIFT < ADDR_W or NSLOTS<<SLOT_SHIFT exceeds 2^MEM_AW.
REQ-005 SHALL have one clock and synchronous active-low reset: clk_sys, input, 1, sole clock, all logic on rising edge; reset_n, input, 1, synchronous active-low reset.
REQ-006 dn_go  input  1  download active level from host.
REQ-007 dn_wr  input  1  one-cycle byte strobe.
REQ-008 dn_addr  input  ADDR_W  byte offset within file.
REQ-009 dn_data  input  8  byte value.
REQ-010 dn_idx  input  8  file index, sampled at download start.
REQ-011 dn_wait  output  1  host SHALL NOT strobe dn_wr while high.
REQ-012 mem_addr  output  MEM_AW / mem_data  output  8 / mem_wr  output  1 / mem_ack  input  1  memory write handshake.
REQ-013 rom_reset  output  1  hold core in reset during index-0 load.
REQ-014 done  output  1  one-cycle completion pulse; err  output  1  sticky per-download error; byte_count  output  ADDR_W+1  accepted bytes; checksum  output  8.

Function
REQ-015 States IDLE, LOAD, DRAIN, DONE; IDLE->LOAD on cycle dn_go=1 sampled in IDLE, latching dn_idx, clearing byte_count, err, checksum.
REQ-016 LOAD->DRAIN when dn_go=0; DRAIN->DONE when FIFO empty and no mem_wr pending; DONE->IDLE after exactly one cycle with done=1.
REQ-017 dn_go high again during DRAIN/DONE SHALL be ignored until IDLE, then LOAD starts next cycle.
REQ-018 Writes SHALL pass through a 2-entry FIFO of {address,data}; dn_wait = FIFO full OR state in {DRAIN, DONE}.
REQ-019 dn_wr in LOAD with FIFO not full and latched index < NSLOTS SHALL push {(idx<<SLOT_SHIFT) | zero-extended dn_addr, dn_data}, increment byte_count, add dn_data mod 256 to checksum.
REQ-020 dn_wr while dn_wait=1 or outside LOAD SHALL be dropped and set err; dn_wr with index >= NSLOTS SHALL be dropped, set err, not counted.
REQ-021 mem_wr SHALL be high whenever FIFO non-empty, presenting head entry; mem_addr/mem_data stable until mem_ack; pop on cycle mem_wr=1 and mem_ack=1.
REQ-022 Latency: dn_wr at cycle N into empty FIFO SHALL give mem_wr=1 at cycle N+1; ack in same cycle as mem_wr allowed, sustaining one byte per cycle.
REQ-023 Simultaneous push and pop SHALL keep occupancy unchanged and preserve order; FIFO pointers wrap modulo 2.
REQ-024 rom_reset SHALL be 1 from LOAD entry with latched index 0 through the DONE cycle inclusive, 0 otherwise.
REQ-025 byte_count SHALL saturate at 2^(ADDR_W+1)-1.

Reset
REQ-026 reset_n=0 at a clock edge SHALL force IDLE, empty FIFO, mem_wr=0, dn_wait=0, done=0, err=0, rom_reset=0, byte_count=0, checksum=0, mem_addr=0, mem_data=0.
REQ-027 Reset mid-LOAD or mid-DRAIN SHALL discard pending FIFO entries without issuing them; after release with dn_go=1, LOAD restarts next cycle.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: checksum accumulates per REQ-019 and holds after done until next LOAD entry.
REQ-029 Macro LOADER_CHECKSUM_EN undefined: checksum tied to 0, no accumulator logic present; all other behaviour identical.

Verification
REQ-030 idx=0, write bytes 0x11,0x22 at addr 0,1, mem_ack tied 1 -> mem_wr at 0x0000000/0x11, 0x0000001/0x22, byte_count=2, rom_reset high throughout, done pulse once.
REQ-031 idx=1, addr 0x3FFF data 0xA5 -> mem_addr=0x0013FFF, rom_reset stays 0.
REQ-032 mem_ack held 0, three back-to-back dn_wr -> dn_wait=1 after second push, third strobe dropped, err=1, byte_count=2.
REQ-033 idx=5 with NSLOTS=2 -> no mem_wr, err=1, byte_count=0, done pulses.
REQ-034 reset_n=0 with 2 entries queued -> next cycle mem_wr=0, dn_wait=0, state IDLE, no further writes.
REQ-035 LOADER_CHECKSUM_EN defined, bytes 0xF0,0x20 -> checksum=0x10; undefined -> checksum=0x00.
